// File: rtl/riscv_v_lmul_seq.sv
// Register-group micro-op sequencer: expands one vector instruction's LMUL group
// into per-register micro-ops with tail-masked byte enables for the register file.
module riscv_v_lmul_seq #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned VLEN_BYTES = 16,
    parameter int unsigned ADDR_W     = $clog2(NUM_REGS),
    parameter int unsigned VL_W       = $clog2(8 * VLEN_BYTES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_vs1,
    input  logic [ADDR_W-1:0]     req_vs2,
    input  logic [ADDR_W-1:0]     req_vd,
    input  logic [1:0]            req_lmul,
    input  logic [VL_W-1:0]       req_vl_bytes,
    input  logic                  kill,
    output logic                  uop_valid,
    input  logic                  uop_ready,
    output logic [ADDR_W-1:0]     uop_rd_addr_A,
    output logic [ADDR_W-1:0]     uop_rd_addr_B,
    output logic [ADDR_W-1:0]     uop_wr_addr,
    output logic [VLEN_BYTES-1:0] uop_wr_en,
    output logic [2:0]            uop_idx,
    output logic                  uop_last,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned SHIFT = $clog2(VLEN_BYTES);

    typedef enum logic [0:0] {IDLE, ISSUE} state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [ADDR_W-1:0]     rd_a_q, rd_a_d, rd_b_q, rd_b_d, wr_q, wr_d;
    logic [VLEN_BYTES-1:0] wr_en_q, wr_en_d;
    logic [2:0]            idx_q, idx_d, last_idx_q, last_idx_d;
    logic                  last_q, last_d, done_q, done_d, err_q, err_d;
    logic [VL_W-1:0]       rem_q, rem_d;

    logic [VL_W-1:0]       cap, vlc;
    logic [ADDR_W-1:0]     ones, amask;
    logic                  misaligned, accept;

    function automatic logic [VLEN_BYTES-1:0] tail_mask(input logic [VL_W-1:0] rem);
        logic [VLEN_BYTES-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < VLEN_BYTES; b++) m[b] = (VL_W'(b) < rem);
        return m;
    endfunction

    assign req_ready = (state_q == IDLE) && !rst;

    always_comb begin
        cap        = VL_W'(VLEN_BYTES) << req_lmul;
        vlc        = (req_vl_bytes < cap) ? req_vl_bytes : cap;
        ones       = '1;
        amask      = ~(ones << req_lmul);
        misaligned = |((req_vs1 | req_vs2 | req_vd) & amask);
        accept     = req_valid && req_ready && !kill;

        state_d    = state_q;
        valid_d    = valid_q;
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        wr_d       = wr_q;
        wr_en_d    = wr_en_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        last_d     = last_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else if (vlc == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        valid_d    = 1'b1;
                        rd_a_d     = req_vs1;
                        rd_b_d     = req_vs2;
                        wr_d       = req_vd;
                        idx_d      = '0;
                        rem_d      = vlc;
                        // Index of the final register actually touched by vl.
                        last_idx_d = 3'((vlc - VL_W'(1)) >> SHIFT);
                        last_d     = (last_idx_d == '0);
                        wr_en_d    = tail_mask(vlc);
                    end
                end
            end
            ISSUE: begin
                if (kill) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (uop_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_a_d  = rd_a_q + ADDR_W'(1);
                        rd_b_d  = rd_b_q + ADDR_W'(1);
                        wr_d    = wr_q + ADDR_W'(1);
                        idx_d   = idx_q + 3'd1;
                        rem_d   = rem_q - VL_W'(VLEN_BYTES);
                        last_d  = (idx_d == last_idx_q);
                        wr_en_d = tail_mask(rem_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            wr_q       <= '0;
            wr_en_q    <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            last_q     <= 1'b0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            wr_q       <= wr_d;
            wr_en_q    <= wr_en_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            last_q     <= last_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign uop_valid     = valid_q;
    assign uop_rd_addr_A = rd_a_q;
    assign uop_rd_addr_B = rd_b_q;
    assign uop_wr_addr   = wr_q;
    assign uop_wr_en     = wr_en_q;
    assign uop_idx       = idx_q;
    assign uop_last      = last_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
